russian_peasant_product_accumulator_8: RTL and testbench

//  Downstream back end of the 8-bit Russian-peasant multiplier; the multiplier is combinational, 8x8->16.

---
 rtl/rp_mult_pkg.sv | 17 +
 rtl/russian_peasant_product_accumulator_8_if.sv | 48 ++++
 rtl/rp_sat_add.sv | 25 ++
 rtl/russian_peasant_product_accumulator_8.sv | 119 +++++++++++
 tb/tb_russian_peasant_product_accumulator_8.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rp_mult_pkg.sv
// Shared definitions for the Russian-peasant multiply-accumulate path.
//   RP_OP_W   : multiplier operand width
//   RP_PROD_W : multiplier product width (2 * RP_OP_W)
//   RP_ACC_W  : default accumulator / block-sum width
//   rp_acc_state_t : accumulator FSM state
package rp_mult_pkg;

  localparam int unsigned RP_OP_W   = 8;
  localparam int unsigned RP_PROD_W = 16;
  localparam int unsigned RP_ACC_W  = 24;

  typedef enum logic {
    ST_ACCUM,
    ST_HOLD
  } rp_acc_state_t;

endpackage

// File: rtl/russian_peasant_product_accumulator_8_if.sv
// Stream interface between the multiplier, the product accumulator and the block consumer.
//   in_valid / in_ready / in_product / in_last : product input stream
//   out_valid / out_ready / out_sum / out_count / out_overflow : block-sum output stream
// Modports:
//   master : the environment (drives products, accepts sums)
//   slave  : the accumulator
interface russian_peasant_product_accumulator_8_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport master (
    output in_valid,
    output in_product,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_count,
    input  out_overflow
  );

  modport slave (
    input  in_valid,
    input  in_product,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_count,
    output out_overflow
  );

endinterface

// File: rtl/rp_sat_add.sv
// Combinational saturating adder.
//   acc    : current accumulator value (ACC_W)
//   addend : unsigned value to add (IN_W, IN_W <= ACC_W)
//   sum    : acc + addend, clamped to 2^ACC_W-1
//   ovf    : the addition saturated
module rp_sat_add #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] wide;

  // One guard bit is enough: acc <= 2^ACC_W-1 and addend < 2^IN_W <= 2^ACC_W.
  always_comb begin
    wide = {1'b0, acc} + (ACC_W + 1)'(addend);
    ovf  = wide[ACC_W];
    sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/russian_peasant_product_accumulator_8.sv
// Back end of the 8-bit Russian-peasant multiplier: sums blocks of COUNT products (or fewer when
// in_last closes a block early) and presents each block sum as one registered output beat.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : slave modport carrying the product input stream and the block-sum output stream
//          (in_valid/in_ready/in_product/in_last, out_valid/out_ready/out_sum/out_count/
//          out_overflow)
module russian_peasant_product_accumulator_8
  import rp_mult_pkg::*;
#(
  parameter int unsigned PROD_W = RP_PROD_W,
  parameter int unsigned ACC_W  = RP_ACC_W,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned CNT_W  = $clog2(COUNT + 1)
) (
  input logic clk,
  input logic rst,
  russian_peasant_product_accumulator_8_if.slave bus
);

  rp_acc_state_t    state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_fire;
  logic             out_fire;
  logic             complete;
  logic [CNT_W-1:0] ncnt;
  logic [ACC_W-1:0] nsum;
  logic             step_ovf;

  rp_sat_add #(
    .IN_W  (PROD_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc    (acc_q),
    .addend (bus.in_product),
    .sum    (nsum),
    .ovf    (step_ovf)
  );

  // Registered output with no skid buffer: while a beat is held, a new product is only taken in
  // the cycle that beat leaves, so the new block can never clobber it.
  assign bus.in_ready = !rst && (state_q == ST_ACCUM || bus.out_ready);

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  assign ncnt     = cnt_q + CNT_W'(1);
  assign complete = (ncnt == CNT_W'(COUNT)) || bus.in_last;

  // ACCUM and HOLD share one input path: in HOLD acc/cnt are already zero, and an input transfer
  // in HOLD implies the held beat leaves in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (in_fire) begin
      if (complete) begin
        out_sum_d   = nsum;
        out_count_d = ncnt;
        out_ovf_d   = ovf_q | step_ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = ST_HOLD;
      end else begin
        acc_d       = nsum;
        cnt_d       = ncnt;
        ovf_d       = ovf_q | step_ovf;
        out_valid_d = 1'b0;
        state_d     = ST_ACCUM;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_russian_peasant_product_accumulator_8.sv
module tb_russian_peasant_product_accumulator_8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  russian_peasant_product_accumulator_8_if #(.PROD_W(16), .ACC_W(24), .CNT_W(3)) bus ();
  russian_peasant_product_accumulator_8_if #(.PROD_W(16), .ACC_W(17), .CNT_W(3)) bus17 ();

  russian_peasant_product_accumulator_8 #(
    .PROD_W (16),
    .ACC_W  (24),
    .COUNT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  russian_peasant_product_accumulator_8 #(
    .PROD_W (16),
    .ACC_W  (17),
    .COUNT  (4)
  ) dut17 (
    .clk (clk),
    .rst (rst),
    .bus (bus17)
  );

  typedef struct packed {
    logic [23:0] sum;
    logic [2:0]  cnt;
    logic        ovf;
  } beat_t;

  int    tests = 0;
  int    fails = 0;
  beat_t sbq[$];
  longint macc = 0;
  int    mcnt = 0;
  bit    movf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: block sum saturating at 2^24-1, closing at 4 products or on last.
  task automatic model_accept(input logic [15:0] p, input logic l);
    longint s;
    beat_t  b;
    s = macc + longint'(p);
    if (s > 64'hFF_FFFF) begin
      s    = 64'hFF_FFFF;
      movf = 1'b1;
    end
    macc = s;
    mcnt++;
    if (mcnt == 4 || l) begin
      b.sum = macc[23:0];
      b.cnt = 3'(mcnt);
      b.ovf = movf;
      sbq.push_back(b);
      macc = 0;
      mcnt = 0;
      movf = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [15:0] p, input logic l);
    int guard;
    guard          = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_last    = l;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 1);
    else model_accept(p, l);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send17(input logic [15:0] p, input logic l);
    bus17.in_valid   = 1'b1;
    bus17.in_product = p;
    bus17.in_last    = l;
    @(negedge clk);
    check("t5_in_ready", 64'(bus17.in_ready), 1);
    @(posedge clk);
    #1;
    bus17.in_valid = 1'b0;
    bus17.in_last  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst  = 1'b1;
    macc = 0;
    mcnt = 0;
    movf = 1'b0;
    sbq.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard: an output transfer happens at the next posedge when valid&&ready at negedge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_beat", 64'(sbq.size()), 1);
      end else begin
        e = sbq.pop_front();
        check("sb_sum", 64'(bus.out_sum), 64'(e.sum));
        check("sb_count", 64'(bus.out_count), 64'(e.cnt));
        check("sb_ovf", 64'(bus.out_overflow), 64'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_product   = '0;
    bus.in_last      = 1'b0;
    bus.out_ready    = 1'b0;
    bus17.in_valid   = 1'b0;
    bus17.in_product = '0;
    bus17.in_last    = 1'b0;
    bus17.out_ready  = 1'b1;

    // T1 reset
    rst = 1'b1;
    @(negedge clk);
    check("t1_in_ready_rst", 64'(bus.in_ready), 0);
    check("t1_out_valid", 64'(bus.out_valid), 0);
    check("t1_out_sum", 64'(bus.out_sum), 0);
    check("t1_out_count", 64'(bus.out_count), 0);
    check("t1_out_ovf", 64'(bus.out_overflow), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_in_ready_after", 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // T2 full block with a zero product
    bus.out_ready = 1'b1;
    send(16'd11270, 1'b0);
    send(16'd16830, 1'b0);
    send(16'd9618, 1'b0);
    check("t2_no_early_valid", 64'(bus.out_valid), 0);
    send(16'd0, 1'b0);
    check("t2_latency_valid", 64'(bus.out_valid), 1);
    check("t2_sum", 64'(bus.out_sum), 37718);
    check("t2_count", 64'(bus.out_count), 4);
    check("t2_ovf", 64'(bus.out_overflow), 0);
    @(posedge clk);
    #1;
    check("t2_valid_drop", 64'(bus.out_valid), 0);

    // T3 early close, then a single-product block
    send(16'd11270, 1'b0);
    send(16'd16830, 1'b1);
    check("t3_sum", 64'(bus.out_sum), 28100);
    check("t3_count", 64'(bus.out_count), 2);
    send(16'd5, 1'b1);
    check("t3_next_sum", 64'(bus.out_sum), 5);
    check("t3_next_count", 64'(bus.out_count), 1);
    @(posedge clk);
    #1;

    // T4 backpressure
    bus.out_ready = 1'b0;
    send(16'd1000, 1'b0);
    send(16'd2000, 1'b0);
    send(16'd3000, 1'b0);
    send(16'd4000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_in_ready_held", 64'(bus.in_ready), 0);
      check("t4_valid_held", 64'(bus.out_valid), 1);
      check("t4_sum_held", 64'(bus.out_sum), 10000);
      check("t4_count_held", 64'(bus.out_count), 4);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'd7, 1'b0);
    check("t4_released", 64'(bus.out_valid), 0);
    send(16'd8, 1'b1);
    check("t4_new_sum", 64'(bus.out_sum), 15);
    check("t4_new_count", 64'(bus.out_count), 2);
    @(posedge clk);
    #1;

    // T5 saturation on the 17-bit instance
    repeat (4) send17(16'd65025, 1'b0);
    check("t5_sat_valid", 64'(bus17.out_valid), 1);
    check("t5_sat_sum", 64'(bus17.out_sum), 131071);
    check("t5_sat_ovf", 64'(bus17.out_overflow), 1);
    check("t5_sat_count", 64'(bus17.out_count), 4);
    repeat (4) send17(16'd1, 1'b0);
    check("t5_clear_sum", 64'(bus17.out_sum), 4);
    check("t5_clear_ovf", 64'(bus17.out_overflow), 0);

    // T6 mid-block reset discards the partial sum
    send(16'd300, 1'b0);
    send(16'd400, 1'b0);
    do_reset(1);
    repeat (4) send(16'd100, 1'b0);
    check("t6_sum", 64'(bus.out_sum), 400);
    check("t6_count", 64'(bus.out_count), 4);
    @(posedge clk);
    #1;

    // Random valid/ready traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_product = (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      bus.in_last    = ($urandom_range(0, 7) == 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) model_accept(bus.in_product, bus.in_last);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
